// File: rtl/char_write_sequencer.sv
// rtl/char_write_sequencer.sv - terminal character writer: PIA handshake, cursor, scroll and clear of screen RAM
// RAM writes are strobed combinationally so they never collide with a display fetch in the same cycle.
module char_write_sequencer #(
   parameter int COLS = 40,
   parameter int ROWS = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] rd,
   input  logic       da,
   output logic       rda_n,
   input  logic       clr_btn,
   input  logic       vid_busy,
   output logic [9:0] mem_addr,
   output logic [5:0] mem_wdata,
   output logic       mem_we,
   output logic [5:0] cur_col,
   output logic [4:0] cur_row,
   output logic [4:0] top_row,
   output logic       busy
);

   localparam int CELLS = COLS * ROWS;

   typedef enum logic [2:0] {
      IDLE, ACCEPT, WRITE, NEWLINE, SCROLL_CLR, CLEAR, WAIT_DA_LOW
   } state_t;

   state_t     state;
   logic       da_s1, da_s2;
   logic       clr_s1, clr_s2, clr_d;
   logic [6:0] code;
   logic [5:0] scnt;
   logic       clr_rise;
   logic [5:0] row_sum;
   logic [4:0] phys_row;

   assign clr_rise = clr_s2 & ~clr_d & (state != CLEAR);
   assign busy     = (state != IDLE);
   assign mem_we   = ((state == WRITE) || (state == SCROLL_CLR) || (state == CLEAR))
                     & ~vid_busy & ~clr_rise;

   // logical cursor row mapped onto the circular RAM row buffer
   always_comb begin
      row_sum  = {1'b0, top_row} + {1'b0, cur_row};
      phys_row = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         da_s1     <= 1'b0;
         da_s2     <= 1'b0;
         clr_s1    <= 1'b0;
         clr_s2    <= 1'b0;
         clr_d     <= 1'b0;
         code      <= '0;
         scnt      <= '0;
         rda_n     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cur_col   <= '0;
         cur_row   <= '0;
         top_row   <= '0;
      end else begin
         da_s1  <= da;
         da_s2  <= da_s1;
         clr_s1 <= clr_btn;
         clr_s2 <= clr_s1;
         clr_d  <= clr_s2;
         if (clr_rise) begin
            state     <= CLEAR;
            rda_n     <= 1'b1;
            code      <= '0;
            mem_addr  <= '0;
            mem_wdata <= 6'h20;
         end else begin
            case (state)
               IDLE: begin
                  if (da_s2) begin
                     code  <= rd;
                     rda_n <= 1'b1;
                     state <= ACCEPT;
                  end
               end
               ACCEPT: begin
                  if (code == 7'h0D) begin
                     state <= NEWLINE;
                  end else if (code < 7'h20) begin
                     state <= WAIT_DA_LOW;
                  end else begin
                     mem_addr  <= 10'(int'(phys_row) * COLS + int'(cur_col));
                     mem_wdata <= code[5:0];
                     state     <= WRITE;
                  end
               end
               WRITE: begin
                  if (!vid_busy) begin
                     if (cur_col == 6'(COLS - 1)) begin
                        cur_col <= '0;
                        state   <= NEWLINE;
                     end else begin
                        cur_col <= cur_col + 6'd1;
                        state   <= WAIT_DA_LOW;
                     end
                  end
               end
               NEWLINE: begin
                  cur_col <= '0;
                  if (cur_row < 5'(ROWS - 1)) begin
                     cur_row <= cur_row + 5'd1;
                     state   <= WAIT_DA_LOW;
                  end else begin
                     mem_addr  <= 10'(int'(top_row) * COLS);
                     mem_wdata <= 6'h20;
                     scnt      <= '0;
                     state     <= SCROLL_CLR;
                  end
               end
               SCROLL_CLR: begin
                  if (!vid_busy) begin
                     if (scnt == 6'(COLS - 1)) begin
                        top_row <= (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;
                        state   <= WAIT_DA_LOW;
                     end else begin
                        scnt     <= scnt + 6'd1;
                        mem_addr <= mem_addr + 10'd1;
                     end
                  end
               end
               CLEAR: begin
                  if (!vid_busy) begin
                     if (mem_addr == 10'(CELLS - 1)) begin
                        cur_col <= '0;
                        cur_row <= '0;
                        top_row <= '0;
                        state   <= WAIT_DA_LOW;
                     end else begin
                        mem_addr <= mem_addr + 10'd1;
                     end
                  end
               end
               WAIT_DA_LOW: begin
                  if (!da_s2) begin
                     rda_n <= 1'b0;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_char_write_sequencer.sv
// tb/tb_char_write_sequencer.sv - directed self-checking bench for char_write_sequencer
module tb_char_write_sequencer;

   logic       clk, rst, da, rda_n, clr_btn, vid_busy, mem_we, busy;
   logic [6:0] rd;
   logic [9:0] mem_addr;
   logic [5:0] mem_wdata, cur_col;
   logic [4:0] cur_row, top_row;

   int checks = 0;
   int failures = 0;
   logic [9:0] log_addr[$];
   logic [5:0] log_data[$];

   char_write_sequencer #(.COLS(40), .ROWS(24)) dut (
      .clk(clk), .rst(rst), .rd(rd), .da(da), .rda_n(rda_n), .clr_btn(clr_btn),
      .vid_busy(vid_busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .cur_col(cur_col), .cur_row(cur_row), .top_row(top_row), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write log; every strobe must avoid display fetches and stay inside the screen
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         checks++;
         if (vid_busy !== 1'b0 || mem_addr >= 10'd960) begin
            failures++;
            $display("FAIL write_guard: addr=%0d vid_busy=%b required addr<960 vid_busy=0", mem_addr, vid_busy);
         end
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_wdata);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic drive_step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_rda_high(input string name);
      int n = 0;
      @(negedge clk);
      while (rda_n !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rda_n !== 1'b1) begin
         failures++;
         $display("FAIL %s_rda_high: rda_n=%b required 1", name, rda_n);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || rda_n !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0 || rda_n !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle: busy=%b rda_n=%b required 0 0", name, busy, rda_n);
      end
   endtask

   task automatic send_char(input logic [6:0] c, input string name);
      drive_step();
      rd = c;
      da = 1'b1;
      wait_rda_high(name);
      drive_step();
      da = 1'b0;
      wait_idle(200, name);
   endtask

   task automatic apply_reset();
      drive_step();
      rst = 1'b1;
      repeat (2) drive_step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; da = 1'b0; clr_btn = 1'b0; vid_busy = 1'b0; rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rda_n, mem_we, busy} !== 3'b000 || mem_addr !== 10'd0 || mem_wdata !== 6'd0) begin
         failures++;
         $display("FAIL reset_outputs: rda_n=%b we=%b busy=%b addr=%0d wdata=%0h required all 0",
                  rda_n, mem_we, busy, mem_addr, mem_wdata);
      end
      checks++;
      if (cur_col !== 6'd0 || cur_row !== 5'd0 || top_row !== 5'd0) begin
         failures++;
         $display("FAIL reset_cursor: col=%0d row=%0d top=%0d required 0 0 0", cur_col, cur_row, top_row);
      end
      drive_step();
      rst = 1'b0;
   endtask

   task automatic test_basic_write();
      log_addr.delete(); log_data.delete();
      drive_step();
      rd = 7'h41;
      da = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || rda_n !== 1'b1) begin
         failures++;
         $display("FAIL basic_accept_cycle: we=%b rda_n=%b required 0 1", mem_we, rda_n);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 6'h01) begin
         failures++;
         $display("FAIL basic_latency: we=%b addr=%0d data=%0h required 1 0 01", mem_we, mem_addr, mem_wdata);
      end
      drive_step();
      da = 1'b0;
      wait_idle(50, "basic");
      checks++;
      if (log_addr.size() != 1 || cur_col !== 6'd1 || cur_row !== 5'd0) begin
         failures++;
         $display("FAIL basic_after: writes=%0d col=%0d row=%0d required 1 1 0", log_addr.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_control_char();
      log_addr.delete(); log_data.delete();
      send_char(7'h07, "control");
      checks++;
      if (log_addr.size() != 0 || cur_col !== 6'd1 || cur_row !== 5'd0) begin
         failures++;
         $display("FAIL control_no_write: writes=%0d col=%0d row=%0d required 0 1 0", log_addr.size(), cur_col, cur_row);
      end
   endtask

   task automatic test_vid_busy_stall();
      log_addr.delete(); log_data.delete();
      drive_step();
      rd = 7'h42;
      da = 1'b1;
      repeat (2) @(posedge clk);
      drive_step();
      vid_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_we[%0d]: we=%b required 0", i, mem_we);
         end
         drive_step();
      end
      vid_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 6'h02) begin
         failures++;
         $display("FAIL stall_release: we=%b addr=%0d data=%0h required 1 1 02", mem_we, mem_addr, mem_wdata);
      end
      drive_step();
      da = 1'b0;
      wait_idle(50, "stall");
      checks++;
      if (log_addr.size() != 1 || cur_col !== 6'd2) begin
         failures++;
         $display("FAIL stall_single_write: writes=%0d col=%0d required 1 2", log_addr.size(), cur_col);
      end
   endtask

   task automatic test_row_fill();
      apply_reset();
      log_addr.delete(); log_data.delete();
      for (int i = 0; i < 40; i++) send_char(7'h60 + 7'(i % 32), "fill");
      checks++;
      if (log_addr.size() != 40) begin
         failures++;
         $display("FAIL fill_count: writes=%0d required 40", log_addr.size());
      end else begin
         for (int i = 0; i < 40; i++) begin
            checks++;
            if (log_addr[i] !== 10'(i) || log_data[i] !== 6'(32 + i % 32)) begin
               failures++;
               $display("FAIL fill_write[%0d]: addr=%0d data=%0h required %0d %0h",
                        i, log_addr[i], log_data[i], i, 32 + i % 32);
            end
         end
      end
      checks++;
      if (cur_col !== 6'd0 || cur_row !== 5'd1) begin
         failures++;
         $display("FAIL fill_wrap: col=%0d row=%0d required 0 1", cur_col, cur_row);
      end
   endtask

   task automatic test_scroll();
      for (int i = 0; i < 22; i++) send_char(7'h0D, "cr");
      checks++;
      if (cur_row !== 5'd23 || top_row !== 5'd0) begin
         failures++;
         $display("FAIL scroll_setup: row=%0d top=%0d required 23 0", cur_row, top_row);
      end
      log_addr.delete(); log_data.delete();
      send_char(7'h0D, "scroll");
      checks++;
      if (log_addr.size() != 40) begin
         failures++;
         $display("FAIL scroll_count: writes=%0d required 40", log_addr.size());
      end else begin
         for (int i = 0; i < 40; i++) begin
            checks++;
            if (log_addr[i] !== 10'(i) || log_data[i] !== 6'h20) begin
               failures++;
               $display("FAIL scroll_write[%0d]: addr=%0d data=%0h required %0d 20", i, log_addr[i], log_data[i], i);
            end
         end
      end
      checks++;
      if (top_row !== 5'd1 || cur_row !== 5'd23 || cur_col !== 6'd0) begin
         failures++;
         $display("FAIL scroll_cursor: top=%0d row=%0d col=%0d required 1 23 0", top_row, cur_row, cur_col);
      end
      log_addr.delete(); log_data.delete();
      send_char(7'h41, "after_scroll");
      checks++;
      if (log_addr.size() != 1 || log_addr[0] !== 10'd0 || log_data[0] !== 6'h01) begin
         failures++;
         $display("FAIL scroll_next_char: writes=%0d addr=%0d required 1 0",
                  log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 10'h3ff);
      end
   endtask

   task automatic test_clear_mid_scroll();
      int n = 0;
      int base;
      log_addr.delete(); log_data.delete();
      drive_step();
      rd = 7'h0D;
      da = 1'b1;
      wait_rda_high("clear");
      drive_step();
      da = 1'b0;
      while (log_addr.size() < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (log_addr.size() < 5) begin
         failures++;
         $display("FAIL clear_scroll_start: writes=%0d required >=5", log_addr.size());
      end
      drive_step();
      clr_btn = 1'b1;
      repeat (3) drive_step();
      clr_btn = 1'b0;
      wait_idle(3000, "clear");
      checks++;
      if (log_addr.size() < 960) begin
         failures++;
         $display("FAIL clear_count: writes=%0d required >=960", log_addr.size());
      end else begin
         base = log_addr.size() - 960;
         for (int i = 0; i < 960; i++) begin
            checks++;
            if (log_addr[base + i] !== 10'(i) || log_data[base + i] !== 6'h20) begin
               failures++;
               $display("FAIL clear_write[%0d]: addr=%0d data=%0h required %0d 20",
                        i, log_addr[base + i], log_data[base + i], i);
            end
         end
      end
      checks++;
      if (cur_col !== 6'd0 || cur_row !== 5'd0 || top_row !== 5'd0 || rda_n !== 1'b0) begin
         failures++;
         $display("FAIL clear_cursor: col=%0d row=%0d top=%0d rda_n=%b required 0 0 0 0",
                  cur_col, cur_row, top_row, rda_n);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_control_char();
      test_vid_busy_stall();
      test_row_fill();
      test_scroll();
      test_clear_mid_scroll();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
